// File: rtl/onehot_to_binary_rs_pkg.sv
// Shared project constants for reservation-station index encoding.
package onehot_to_binary_rs_pkg;

  localparam int RS_SIZE = 32;

  localparam int RS_IDX_W = $clog2(RS_SIZE);

endpackage

// File: rtl/onehot_to_binary_comb.sv
// Combinational one-hot to binary encoder with any / multi-hot detection.
// Pure logic, no state; the wrapper registers every output.
module onehot_to_binary_comb #(
  parameter int N = 32
) (
  input  logic [N-1:0]         oh,
  output logic [$clog2(N)-1:0] bin,
  output logic                 any,
  output logic                 multi
);

  localparam int W = $clog2(N);
  localparam int P = 1 << W;

  // Heap-ordered tree: node k has children 2k and 2k+1, leaves at P..2P-1.
  logic [2*P-1:1] tree_any;
  logic [2*P-1:1] tree_multi;

  always_comb begin
    bin = '0;
    for (int k = 0; k < W; k++) begin
      for (int i = 0; i < N; i++) begin
        if (((i >> k) & 1) == 1) begin
          bin[k] = bin[k] | oh[i];
        end
      end
    end
  end

  always_comb begin
    tree_any   = '0;
    tree_multi = '0;
    for (int i = 0; i < N; i++) begin
      tree_any[P+i] = oh[i];
    end
    for (int k = P - 1; k >= 1; k--) begin
      tree_any[k]   = tree_any[2*k] | tree_any[2*k+1];
      tree_multi[k] = tree_multi[2*k] | tree_multi[2*k+1]
                    | (tree_any[2*k] & tree_any[2*k+1]);
    end
  end

  assign any   = tree_any[1];
  assign multi = tree_multi[1];

endmodule

// File: rtl/onehot_to_binary_rs.sv
// Registered reservation-station one-hot encoder: one-cycle latency, new input every cycle.
// No handshake; synchronous active-high reset clears all outputs and wins over oh.
module onehot_to_binary_rs
  import onehot_to_binary_rs_pkg::*;
#(
  parameter int N = RS_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         oh,
  output logic [$clog2(N)-1:0] bin,
  output logic                 valid,
  output logic                 multi_hot
);

  localparam int W = $clog2(N);

  logic [W-1:0] enc_bin;
  logic         enc_any;
  logic         enc_multi;

  logic [W-1:0] bin_d, bin_q;
  logic         valid_d, valid_q;
  logic         multi_hot_d, multi_hot_q;

  onehot_to_binary_comb #(.N(N)) u_comb (
    .oh    (oh),
    .bin   (enc_bin),
    .any   (enc_any),
    .multi (enc_multi)
  );

  always_comb begin
    bin_d       = enc_bin;
    valid_d     = enc_any;
    multi_hot_d = enc_multi;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q       <= '0;
      valid_q     <= 1'b0;
      multi_hot_q <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      valid_q     <= valid_d;
      multi_hot_q <= multi_hot_d;
    end
  end

  assign bin       = bin_q;
  assign valid     = valid_q;
  assign multi_hot = multi_hot_q;

endmodule

// File: tb/tb_onehot_to_binary_rs.sv
// Scoreboard bench for onehot_to_binary_rs at the default 32-entry size.
module tb_onehot_to_binary_rs;
  import onehot_to_binary_rs_pkg::*;

  localparam int N = RS_SIZE;
  localparam int W = $clog2(N);

  typedef struct packed {
    logic [W-1:0] bin;
    logic         valid;
    logic         multi_hot;
  } exp_t;

  logic         clock;
  logic         reset;
  logic [N-1:0] oh;
  logic [W-1:0] bin;
  logic         valid;
  logic         multi_hot;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  onehot_to_binary_rs dut (
    .clock     (clock),
    .reset     (reset),
    .oh        (oh),
    .bin       (bin),
    .valid     (valid),
    .multi_hot (multi_hot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic rst, input logic [N-1:0] v);
    exp_t e;
    int   cnt;
    e   = '0;
    cnt = 0;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          cnt++;
          e.bin = e.bin | W'(i);
        end
      end
      e.valid     = (cnt > 0);
      e.multi_hot = (cnt > 1);
    end
    return e;
  endfunction

  // Drive at the falling edge, then compare just after the loading edge.
  task automatic step(input string tag, input logic rst, input logic [N-1:0] v);
    exp_t e;
    @(negedge clock);
    reset = rst;
    oh    = v;
    exp_q.push_back(model(rst, v));
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_bin"},   32'(bin),       32'(e.bin));
      check_eq({tag, "_valid"}, 32'(valid),     32'(e.valid));
      check_eq({tag, "_multi"}, 32'(multi_hot), 32'(e.multi_hot));
    end
  endtask

  initial begin
    logic [N-1:0] v;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    oh       = '1;

    step("rst0", 1'b1, 32'hFFFF_FFFF);
    step("rst1", 1'b1, 32'hFFFF_FFFF);

    for (int i = N - 1; i >= 0; i--) begin
      v = '0;
      v[i] = 1'b1;
      step("walk_a", 1'b0, v);
      step("walk_b", 1'b0, v);
    end

    step("zero",    1'b0, 32'h0000_0000);
    step("pair6",   1'b0, 32'h0000_0006);
    step("ends",    1'b0, 32'h8000_0001);
    step("all",     1'b0, 32'hFFFF_FFFF);

    step("b2b_10",  1'b0, 32'h0000_0010);
    step("b2b_400", 1'b0, 32'h0000_0400);
    step("b2b_1",   1'b0, 32'h0000_0001);

    step("mid_rst", 1'b1, 32'h0000_0100);
    step("post_rst", 1'b0, 32'h0000_0100);

    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 2))
        0: v = N'(1) << $urandom_range(0, N - 1);
        1: v = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
        default: v = N'($urandom());
      endcase
      step("rand", 1'b0, v);
    end

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_to_binary_rs.md
ONEHOT_TO_BINARY_RS -- requirements
Module: onehot_to_binary_rs

Interface
REQ-001 Parameter N, default `RS_SIZE (32), number of one-hot input lines (reservation-station entries); N SHALL be >= 2.
REQ-002 Port clock  input  1  single system clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-004 Port oh  input  N  one-hot vector; bit i set selects RS entry i.
REQ-005 Port bin  output  $clog2(N)  registered binary index of the set bit.
REQ-006 Port valid  output  1  registered; 1 when the sampled oh had at least one bit set.
REQ-007 Port multi_hot  output  1  registered; 1 when the sampled oh had two or more bits set.

Function
REQ-008 On each rising clock edge with reset low, bin SHALL load the encoded index of oh as sampled at that edge; latency exactly one cycle, no handshake, a new input is accepted every cycle.
REQ-009 For oh with exactly bit i set, bin SHALL equal i (N=32: 0x8000_0000 -> 0x1F, 0x0000_0001 -> 0x00).
REQ-010 For oh == 0, bin SHALL be 0, valid 0, multi_hot 0.
REQ-011 For oh with exactly one bit set, valid SHALL be 1 and multi_hot 0.
REQ-012 For oh with two or more bits set, bin SHALL be the bitwise OR of the indices of all set bits, valid 1, multi_hot 1.
REQ-013 Encoding SHALL be an OR-reduction: bin bit k = OR of oh[i] over all i whose bit k is 1; no priority logic.
REQ-014 multi_hot SHALL be computed as a balanced tree of (any, more-than-one) pairs, depth O(log N).
REQ-015 Input bits above N-1 do not exist; when N is not a power of two, unused index codes SHALL never appear for one-hot inputs.
REQ-016 Outputs SHALL hold their value between edges regardless of input glitches; no combinational path from oh to any output.

Reset
REQ-017 While reset is high at a rising edge, bin SHALL become 0, valid 0, multi_hot 0; reset takes priority over oh.
REQ-018 First edge with reset low SHALL register the current oh normally; no extra recovery cycle.
REQ-019 Reset asserted mid-stream SHALL discard the input sampled at that edge.

Structure
REQ-020 RS_SIZE SHALL come from the shared project header/package (include.svh); no local redefinition.
REQ-021 A single combinational sub-module onehot_to_binary_comb (parameter N; ports oh, bin, any, multi) SHALL implement REQ-012..REQ-014; onehot_to_binary_rs wraps it with the output registers.
REQ-022 Output width SHALL be derived as $clog2(N); no hard-coded widths.

Verification
REQ-023 Reset high two cycles with oh=0xFFFF_FFFF -> bin=0, valid=0, multi_hot=0 after each edge.
REQ-024 Walking one from 0x8000_0000 down to 0x0000_0001, one step per two cycles -> bin decrements 0x1F to 0x00, valid=1, multi_hot=0, each checked one edge after application.
REQ-025 oh=0 -> bin=0, valid=0, multi_hot=0.
REQ-026 oh=0x0000_0006 -> bin=0x03, valid=1, multi_hot=1; oh=0x8000_0001 -> bin=0x1F, multi_hot=1.
REQ-027 Back-to-back inputs 0x10, 0x400, 0x1 on consecutive edges -> bin 0x04, 0x0A, 0x00 on the following consecutive edges.
REQ-028 Reset asserted on the edge where oh=0x100 -> bin stays 0; next edge with reset low and oh=0x100 -> bin=0x08.
